// File: rtl/ncl_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ncl_seq_pkg : shared types/constants for the clocked NCL multiplier shell |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
package ncl_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_NULL  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [1:0] c_FAULT_NONE    = 2'b00;
    localparam logic [1:0] c_FAULT_RAILS   = 2'b01;
    localparam logic [1:0] c_FAULT_TIMEOUT = 2'b10;

    // Dual-rail bit i occupies [2i+1:2i]; offsets of each rail within a pair
    localparam int c_RAIL_T = 1;
    localparam int c_RAIL_F = 0;

    localparam int c_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/ncl_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ncl_sync : multi-flop synchronizer bringing NCL signals into clk domain   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module ncl_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ncl_mult_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ncl_mult_seq : clocked valid/ready shell around a dual-rail NCL multiplier|
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module ncl_mult_seq
    import ncl_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 init_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic [2*WIDTH-1:0]   ncl_a,
    output logic [2*WIDTH-1:0]   ncl_b,
    input  logic                 ncl_ki,
    input  logic [4*WIDTH-1:0]   ncl_p,
    output logic                 ncl_ko,
    output logic                 fault,
    output logic [1:0]           fault_code
);

    localparam int                 c_PW       = 2 * WIDTH;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic               w_ki_s;
    logic [2*c_PW-1:0]  w_p_s;
    logic [2*c_PW-1:0]  r_p_prev;

    ncl_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_ki (
        .clk    (clk),
        .init_n (init_n),
        .i_d    (ncl_ki),
        .o_q    (w_ki_s)
    );

    ncl_sync #(.WIDTH(2*c_PW), .STAGES(SYNC_STAGES)) u_sync_p (
        .clk    (clk),
        .init_n (init_n),
        .i_d    (ncl_p),
        .o_q    (w_p_s)
    );

    logic              w_one_hot;
    logic              w_any_both;
    logic [c_PW-1:0]   w_true;
    logic [c_PW-1:0]   w_a_enc;
    logic [c_PW-1:0]   w_b_enc;

    always_comb begin
        w_one_hot  = 1'b1;
        w_any_both = 1'b0;
        w_true     = '0;
        for (int i = 0; i < c_PW; i++) begin
            w_true[i] = w_p_s[2*i+c_RAIL_T];
            if (w_p_s[2*i+c_RAIL_T] == w_p_s[2*i+c_RAIL_F]) w_one_hot  = 1'b0;
            if (w_p_s[2*i+c_RAIL_T] && w_p_s[2*i+c_RAIL_F]) w_any_both = 1'b1;
        end
    end

    always_comb begin
        w_a_enc = '0;
        w_b_enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_a_enc[2*i+c_RAIL_T] = a[i];
            w_a_enc[2*i+c_RAIL_F] = ~a[i];
            w_b_enc[2*i+c_RAIL_T] = b[i];
            w_b_enc[2*i+c_RAIL_F] = ~b[i];
        end
    end

    // A product observation only counts once two consecutive samples agree
    logic w_stable, w_complete, w_null, w_illegal;
    assign w_stable   = (w_p_s == r_p_prev);
    assign w_complete = w_stable & w_one_hot;
    assign w_null     = w_stable & (w_p_s == '0);
    assign w_illegal  = w_stable & w_any_both;

    state_t             r_state, w_state_nxt;
    logic               w_accept, w_capture, w_rail_err, w_tmo;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_in_ready, r_out_valid, r_ko, r_fault;
    logic [c_PW-1:0]    r_p, r_ncl_a, r_ncl_b;
    logic [1:0]         r_fault_code;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_rail_err  = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_illegal)                                   w_rail_err = 1'b1;
                else if (w_ki_s && w_complete && !r_out_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_NULL;
                end
                else if (r_cnt == c_CNT_LAST)                    w_tmo = 1'b1;
            end
            ST_NULL: begin
                if (w_illegal)                  w_rail_err  = 1'b1;
                else if (!w_ki_s && w_null)     w_state_nxt = ST_IDLE;
                else if (r_cnt == c_CNT_LAST)   w_tmo       = 1'b1;
            end
            default: w_state_nxt = ST_FAULT;
        endcase
        if (w_rail_err || w_tmo) w_state_nxt = ST_FAULT;
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_p_prev     <= '0;
            r_cnt        <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_ko         <= 1'b0;
            r_p          <= '0;
            r_ncl_a      <= '0;
            r_ncl_b      <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= c_FAULT_NONE;
        end else begin
            r_p_prev   <= w_p_s;
            r_in_ready <= (w_state_nxt == ST_IDLE);
            r_ko       <= (w_state_nxt == ST_NULL) || (w_state_nxt == ST_FAULT);

            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if (r_state == ST_DATA || r_state == ST_NULL)
                r_cnt <= r_cnt + c_CNT_W'(1);

            if (w_accept) begin
                r_ncl_a <= w_a_enc;
                r_ncl_b <= w_b_enc;
            end else if (w_state_nxt != ST_DATA) begin
                r_ncl_a <= '0;
                r_ncl_b <= '0;
            end

            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_p         <= w_true;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_rail_err) begin
                r_fault      <= 1'b1;
                r_fault_code <= c_FAULT_RAILS;
            end else if (w_tmo) begin
                r_fault      <= 1'b1;
                r_fault_code <= c_FAULT_TIMEOUT;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign p          = r_p;
    assign ncl_a      = r_ncl_a;
    assign ncl_b      = r_ncl_b;
    assign ncl_ko     = r_ko;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule
`default_nettype wire

// File: tb/tb_ncl_mult_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ncl_mult_seq : scoreboard bench with behavioural NCL array model       |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_ncl_mult_seq;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 255;

    localparam int M_IDEAL  = 0;
    localparam int M_BAD    = 1;
    localparam int M_DEAD   = 2;
    localparam int M_GLITCH = 3;

    logic        clk = 1'b0;
    logic        init_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [15:0] p, ncl_a, ncl_b;
    logic        ncl_ki, ncl_ko, fault;
    logic [31:0] ncl_p;
    logic [1:0]  fault_code;

    int          n_vec = 0;
    int          n_bad = 0;
    int          mode  = M_IDEAL;
    logic        gl_done = 1'b0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    ncl_mult_seq #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .init_n     (init_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .p          (p),
        .ncl_a      (ncl_a),
        .ncl_b      (ncl_b),
        .ncl_ki     (ncl_ki),
        .ncl_p      (ncl_p),
        .ncl_ko     (ncl_ko),
        .fault      (fault),
        .fault_code (fault_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc16(input logic [15:0] x);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[2*i+1] = x[i];
            r[2*i]   = ~x[i];
        end
        return r;
    endfunction

    function automatic logic complete8(input logic [15:0] r);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) if (r[2*i+1] == r[2*i]) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [7:0] dec8(input logic [15:0] r);
        logic [7:0] x;
        for (int i = 0; i < 8; i++) x[i] = r[2*i+1];
        return x;
    endfunction

    // Behavioural array: DATA wave when inputs are DATA and ko asks for DATA, NULL wave on the converse
    always @(negedge clk) begin
        logic [7:0]         ax, bx;
        logic signed [15:0] prod;
        logic [31:0]        full;
        if (mode != M_GLITCH) gl_done = 1'b0;
        if (!init_n) begin
            ncl_p  = '0;
            ncl_ki = 1'b0;
        end else if (mode != M_DEAD) begin
            if (!ncl_ko && complete8(ncl_a) && complete8(ncl_b)) begin
                ax   = dec8(ncl_a);
                bx   = dec8(ncl_b);
                prod = $signed(ax) * $signed(bx);
                full = enc16(prod);
                if (mode == M_BAD) full[7:6] = 2'b11;
                if (mode == M_GLITCH && !gl_done) begin
                    ncl_p   = {full[31:16], 16'h0000};
                    gl_done = 1'b1;
                end else begin
                    ncl_p = full;
                end
                ncl_ki = 1'b1;
            end else if (ncl_ko && ncl_a == '0 && ncl_b == '0) begin
                ncl_p  = '0;
                ncl_ki = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (init_n && out_valid && out_ready) begin
            if (sb.size() == 0) chk("spurious_out", {31'd0, out_valid}, 32'd0);
            else                chk("product", {16'd0, p}, {16'd0, sb.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        init_n = 1'b0;
        tick();
        init_n = 1'b1;
        tick();
    endtask

    task automatic send(input logic [7:0] av, input logic [7:0] bv);
        for (int i = 0; i < 200 && !in_ready; i++) tick();
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        chk(tag, sb.size(), 32'd0);
    endtask

    initial begin
        int n;
        init_n    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        ncl_p     = '0;
        ncl_ki    = 1'b0;
        #3;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ncl_a",     {16'd0, ncl_a},     32'd0);
        chk("rst_ncl_ko",    {31'd0, ncl_ko},    32'd0);
        chk("rst_fault",     {29'd0, fault, fault_code}, 32'd0);
        tick();
        tick();
        init_n = 1'b1;
        tick();
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // -128 * -128 through a full DATA/NULL cycle
        out_ready = 1'b1;
        sb.push_back(16'h4000);
        send(8'h80, 8'h80);
        chk("enc_ncl_a", {16'd0, ncl_a}, 32'h0000_9555);
        chk("enc_ncl_b", {16'd0, ncl_b}, 32'h0000_9555);
        drain("drain_4000");
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_ncl_a", {16'd0, ncl_a},    32'd0);
        chk("idle_ko",    {31'd0, ncl_ko},   32'd0);

        // Back-to-back with consumer stalled: second result must wait
        out_ready = 1'b0;
        sb.push_back(16'hFFFF);
        send(8'hFF, 8'h01);
        sb.push_back(16'hC080);
        send(8'h7F, 8'h80);
        repeat (20) tick();
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_p",     {16'd0, p},         32'h0000_FFFF);
        chk("stall_ko",    {31'd0, ncl_ko},    32'd0);
        chk("stall_ready", {31'd0, in_ready},  32'd0);
        out_ready = 1'b1;
        drain("drain_b2b");

        // One partial sample before the real product
        mode = M_GLITCH;
        sb.push_back(16'h0023);
        send(8'd5, 8'd7);
        drain("drain_glitch");
        mode = M_IDEAL;
        for (int i = 0; i < 50 && !in_ready; i++) tick();

        // Asynchronous reset while in NULL abandons the transaction
        out_ready = 1'b0;
        send(8'd3, 8'd3);
        for (int i = 0; i < 50 && !ncl_ko; i++) tick();
        chk("reach_null_ko", {31'd0, ncl_ko}, 32'd1);
        init_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ko",        {31'd0, ncl_ko},    32'd0);
        chk("arst_p",         {16'd0, p},         32'd0);
        chk("arst_in_ready",  {31'd0, in_ready},  32'd0);
        tick();
        init_n = 1'b1;
        tick();
        chk("arst_ready_up", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        sb.push_back(16'hFFF1);
        send(8'd5, 8'hFD);
        drain("drain_fff1");

        // Both rails of product bit 3 high
        do_reset();
        mode = M_BAD;
        send(8'd2, 8'd3);
        for (int i = 0; i < 50 && !fault; i++) tick();
        chk("rail_fault",      {31'd0, fault},      32'd1);
        chk("rail_fault_code", {30'd0, fault_code}, 32'd1);
        chk("rail_ko",         {31'd0, ncl_ko},     32'd1);
        repeat (5) tick();
        chk("rail_in_ready",   {31'd0, in_ready},   32'd0);
        chk("rail_ncl_a",      {16'd0, ncl_a},      32'd0);
        chk("rail_out_valid",  {31'd0, out_valid},  32'd0);

        // Array never responds: timeout counted from DATA entry
        mode = M_DEAD;
        do_reset();
        send(8'd1, 8'd1);
        n = 0;
        for (int i = 0; i < TIMEOUT + 50 && fault_code != 2'b10; i++) begin
            tick();
            n++;
        end
        chk("tmo_code",   {30'd0, fault_code}, 32'd2);
        chk("tmo_cycles", n,                   TIMEOUT);
        chk("tmo_ko",     {31'd0, ncl_ko},     32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
